// File: rtl/trena_rx_serial_pkg.sv
// Shared constants for the trena serial receiver: ASCII codes, FSM encodings, bit-time formula.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trena_rx_serial_pkg;

    localparam logic [6:0] ASCII_0   = 7'h30;
    localparam logic [6:0] ASCII_9   = 7'h39;
    localparam logic [6:0] ASCII_FIM = 7'h23;

    // Character receiver states
    typedef enum logic [2:0] {
        RX_OCIOSO   = 3'd0,
        RX_INICIO   = 3'd1,
        RX_DADOS    = 3'd2,
        RX_PARIDADE = 3'd3,
        RX_PARADA   = 3'd4
    } rx_estado_t;

    // Frame parser states; the value is exported as db_estado
    typedef enum logic [3:0] {
        ESPERA_C   = 4'd0,
        ESPERA_D   = 4'd1,
        ESPERA_U   = 4'd2,
        ESPERA_FIM = 4'd3
    } quadro_estado_t;

    // Clocks per bit time, truncated
    function automatic int ciclos_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/rx_serial_7E1.sv
// UART character receiver, 7 data bits, even parity, 1 stop bit, with 2-FF input synchronizer.
// Latency: char_valido/erro_serial asserted combinationally in the cycle of the stop-bit mid-sample.
// Backpressure: none; the line cannot be stalled, every character is reported once.
module rx_serial_7E1
    import trena_rx_serial_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [6:0] char,
    output logic       char_valido,
    output logic       erro_serial
);

    localparam int CICLOS_BIT = ciclos_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int MEIO_BIT   = CICLOS_BIT / 2;
    localparam int CW         = $clog2(CICLOS_BIT + 1);

    rx_estado_t   estado, prox_estado;
    logic [1:0]   sinc;
    logic         rx;
    logic         rx_ant;
    logic [CW-1:0] cnt;
    logic [2:0]   n_bits;
    logic [6:0]   desloc;
    logic         paridade_rx;
    logic         fim_meio;
    logic         fim_bit;
    logic         paridade_ok;

    assign rx          = sinc[1];
    assign fim_meio    = (cnt == CW'(MEIO_BIT - 1));
    assign fim_bit     = (cnt == CW'(CICLOS_BIT - 1));
    // Even parity: data plus parity bit must have an even number of ones
    assign paridade_ok = ~(^{desloc, paridade_rx});
    assign char        = desloc;

    // Synchronizer and edge-detect history; reset to idle-high so reset release is not a start edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc   <= 2'b11;
            rx_ant <= 1'b1;
        end else begin
            sinc   <= {sinc[0], entrada_serial};
            rx_ant <= sinc[1];
        end
    end

    // Character FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= RX_OCIOSO;
        else        estado <= prox_estado;
    end

    // Character FSM next state and per-character result strobes
    always_comb begin
        prox_estado = estado;
        char_valido = 1'b0;
        erro_serial = 1'b0;
        case (estado)
            RX_OCIOSO:   if (rx_ant && !rx) prox_estado = RX_INICIO;
            // High at mid start bit is a glitch: drop it silently
            RX_INICIO:   if (fim_meio) prox_estado = rx ? RX_OCIOSO : RX_DADOS;
            RX_DADOS:    if (fim_bit && n_bits == 3'd6) prox_estado = RX_PARIDADE;
            RX_PARIDADE: if (fim_bit) prox_estado = RX_PARADA;
            RX_PARADA: begin
                if (fim_bit) begin
                    prox_estado = RX_OCIOSO;
                    if (rx && paridade_ok) char_valido = 1'b1;
                    else                   erro_serial = 1'b1;
                end
            end
            default:     prox_estado = RX_OCIOSO;
        endcase
    end

    // Bit-time counter, bit index, data shift register and parity capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            n_bits      <= '0;
            desloc      <= '0;
            paridade_rx <= 1'b0;
        end else begin
            if (estado == RX_OCIOSO || prox_estado != estado || fim_bit) cnt <= '0;
            else                                                       cnt <= cnt + 1'b1;

            if (estado == RX_INICIO) n_bits <= '0;
            else if (estado == RX_DADOS && fim_bit) begin
                n_bits <= n_bits + 1'b1;
                desloc <= {rx, desloc[6:1]};
            end

            if (estado == RX_PARIDADE && fim_bit) paridade_rx <= rx;
        end
    end

endmodule

// File: rtl/trena_rx_serial.sv
// Trena frame receiver: three ASCII digits then '#', presented as 12-bit BCD with a pronto strobe.
// Latency: pronto/medida registered, 1 clock after the stop-bit mid-sample of '#'.
// Backpressure: none; outputs are strobes and a held value, no handshake.
module trena_rx_serial
    import trena_rx_serial_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro_serial,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    logic [6:0]     char;
    logic           char_valido;
    logic           erro_rx;
    logic           eh_digito;
    quadro_estado_t estado, prox_estado;
    logic [11:0]    sombra, sombra_nxt;
    logic [11:0]    medida_nxt;
    logic           pronto_nxt;
    logic           erro_formato_nxt;

    rx_serial_7E1 #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .char           (char),
        .char_valido    (char_valido),
        .erro_serial    (erro_rx)
    );

    assign eh_digito = (char >= ASCII_0) && (char <= ASCII_9);
    assign db_estado = estado;

    // Frame FSM next state, shadow digit capture and output strobes
    always_comb begin
        prox_estado      = estado;
        sombra_nxt       = sombra;
        medida_nxt       = medida;
        pronto_nxt       = 1'b0;
        erro_formato_nxt = 1'b0;
        if (erro_rx) begin
            // A corrupted character invalidates whatever frame was in progress
            prox_estado = ESPERA_C;
            sombra_nxt  = '0;
        end else if (char_valido) begin
            case (estado)
                ESPERA_C: begin
                    if (eh_digito) begin
                        sombra_nxt[11:8] = char[3:0];
                        prox_estado      = ESPERA_D;
                    end else if (char != ASCII_FIM) begin
                        // A '#' here is just a resync marker we are already aligned to
                        erro_formato_nxt = 1'b1;
                        sombra_nxt       = '0;
                    end
                end
                ESPERA_D: begin
                    if (eh_digito) begin
                        sombra_nxt[7:4] = char[3:0];
                        prox_estado     = ESPERA_U;
                    end else begin
                        erro_formato_nxt = 1'b1;
                        sombra_nxt       = '0;
                        prox_estado      = ESPERA_C;
                    end
                end
                ESPERA_U: begin
                    if (eh_digito) begin
                        sombra_nxt[3:0] = char[3:0];
                        prox_estado     = ESPERA_FIM;
                    end else begin
                        erro_formato_nxt = 1'b1;
                        sombra_nxt       = '0;
                        prox_estado      = ESPERA_C;
                    end
                end
                ESPERA_FIM: begin
                    if (char == ASCII_FIM) begin
                        medida_nxt = sombra;
                        pronto_nxt = 1'b1;
                    end else begin
                        erro_formato_nxt = 1'b1;
                        sombra_nxt       = '0;
                    end
                    prox_estado = ESPERA_C;
                end
                default: prox_estado = ESPERA_C;
            endcase
        end
    end

    // Frame state, shadow register and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= ESPERA_C;
            sombra       <= '0;
            medida       <= '0;
            pronto       <= 1'b0;
            erro_serial  <= 1'b0;
            erro_formato <= 1'b0;
        end else begin
            estado       <= prox_estado;
            sombra       <= sombra_nxt;
            medida       <= medida_nxt;
            pronto       <= pronto_nxt;
            erro_serial  <= erro_rx;
            erro_formato <= erro_formato_nxt;
        end
    end

endmodule

// File: tb/tb_trena_rx_serial.sv
// Directed bench for trena_rx_serial: UART frames driven at 115200 baud with 250 clocks per bit.
// Latency: pronto checked against start edge of '#' within +/-2 clocks.
// Backpressure: n/a.
module tb_trena_rx_serial;

    localparam int CB         = 250;
    localparam int CLOCK_FREQ = CB * 115200;
    localparam int LAT_ALVO   = 2 + (19 * CB) / 2 + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        entrada_serial = 1'b1;
    logic [11:0] medida;
    logic        pronto;
    logic        erro_serial;
    logic        erro_formato;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;
    int ciclo = 0;
    int t_start = 0;
    int n_pronto = 0;
    int n_eser = 0;
    int n_efmt = 0;
    logic eser_ant = 1'b0;
    logic efmt_ant = 1'b0;
    logic pronto_ant = 1'b0;
    logic [11:0] esperado[$];

    trena_rx_serial #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (115200)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .medida         (medida),
        .pronto         (pronto),
        .erro_serial    (erro_serial),
        .erro_formato   (erro_formato),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    // Scoreboard monitor: pops expected medida on every pronto and checks strobe widths
    always @(negedge clock) begin
        if (pronto) begin
            int lat;
            logic [11:0] exp_m;
            n_pronto++;
            checks++;
            assert (esperado.size() > 0) else begin
                errors++;
                $error("FAIL pronto_unexpected observed medida=%h required no pronto", medida);
            end
            if (esperado.size() > 0) begin
                exp_m = esperado.pop_front();
                checks++;
                assert (medida === exp_m) else begin
                    errors++;
                    $error("FAIL medida observed=%h required=%h", medida, exp_m);
                end
            end
            lat = ciclo - t_start;
            checks++;
            assert (lat >= LAT_ALVO - 2 && lat <= LAT_ALVO + 2) else begin
                errors++;
                $error("FAIL latency observed=%0d required=%0d+/-2", lat, LAT_ALVO);
            end
            checks++;
            assert (!pronto_ant) else begin
                errors++;
                $error("FAIL pronto_width observed=2+ cycles required=1");
            end
        end
        if (erro_serial) begin
            n_eser++;
            checks++;
            assert (!eser_ant) else begin
                errors++;
                $error("FAIL erro_serial_width observed=2+ cycles required=1");
            end
        end
        if (erro_formato) begin
            n_efmt++;
            checks++;
            assert (!efmt_ant) else begin
                errors++;
                $error("FAIL erro_formato_width observed=2+ cycles required=1");
            end
        end
        pronto_ant = pronto;
        eser_ant   = erro_serial;
        efmt_ant   = erro_formato;
    end

    task automatic chk(input string tag, input int obs, input int req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    // One 7E1 character; bits change on the falling clock edge
    task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop);
        logic [9:0] quadro;
        quadro = {~bad_stop, (^c) ^ bad_par, c, 1'b0};
        @(negedge clock);
        t_start = ciclo;
        for (int i = 0; i < 10; i++) begin
            entrada_serial = quadro[i];
            repeat (CB) @(negedge clock);
        end
        entrada_serial = 1'b1;
    endtask

    task automatic send_frame(input logic [6:0] c, input logic [6:0] d, input logic [6:0] u);
        send_char(c, 1'b0, 1'b0);
        send_char(d, 1'b0, 1'b0);
        send_char(u, 1'b0, 1'b0);
        esperado.push_back({c[3:0], d[3:0], u[3:0]});
        send_char(7'h23, 1'b0, 1'b0);
    endtask

    initial begin
        int p0, s0, f0;

        // Reset asserted during idle
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_medida", int'(medida), 0);
        chk("rst_pronto", int'(pronto), 0);
        chk("rst_erro_serial", int'(erro_serial), 0);
        chk("rst_erro_formato", int'(erro_formato), 0);
        chk("rst_db_estado", int'(db_estado), 0);
        reset = 1'b1;
        repeat (CB) @(negedge clock);

        // Valid frame 123#
        p0 = n_pronto; s0 = n_eser; f0 = n_efmt;
        send_frame(7'h31, 7'h32, 7'h33);
        repeat (10) @(negedge clock);
        chk("f123_pronto_count", n_pronto - p0, 1);
        chk("f123_medida", int'(medida), 12'h123);
        chk("f123_db_estado", int'(db_estado), 0);
        chk("f123_no_errors", (n_eser - s0) + (n_efmt - f0), 0);

        // Parity error on '4' in 456#: 5,6 then restart; '#' lands in ESPERA_U
        p0 = n_pronto; s0 = n_eser; f0 = n_efmt;
        send_char(7'h34, 1'b1, 1'b0);
        send_char(7'h35, 1'b0, 1'b0);
        send_char(7'h36, 1'b0, 1'b0);
        send_char(7'h23, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        chk("par_erro_serial", n_eser - s0, 1);
        chk("par_erro_formato", n_efmt - f0, 1);
        chk("par_no_pronto", n_pronto - p0, 0);
        chk("par_medida_held", int'(medida), 12'h123);
        send_frame(7'h30, 7'h34, 7'h35);
        repeat (10) @(negedge clock);
        chk("f045_medida", int'(medida), 12'h045);

        // Format error: 12#
        p0 = n_pronto; f0 = n_efmt;
        send_char(7'h31, 1'b0, 1'b0);
        send_char(7'h32, 1'b0, 1'b0);
        send_char(7'h23, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        chk("fmt_erro_formato", n_efmt - f0, 1);
        chk("fmt_no_pronto", n_pronto - p0, 0);
        chk("fmt_medida_held", int'(medida), 12'h045);
        chk("fmt_db_estado", int'(db_estado), 0);
        send_frame(7'h39, 7'h39, 7'h39);
        repeat (10) @(negedge clock);
        chk("f999_medida", int'(medida), 12'h999);

        // 100-cycle glitch: no event of any kind
        p0 = n_pronto; s0 = n_eser; f0 = n_efmt;
        @(negedge clock);
        entrada_serial = 1'b0;
        repeat (100) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (3 * CB) @(negedge clock);
        chk("glitch_no_events", (n_pronto - p0) + (n_eser - s0) + (n_efmt - f0), 0);
        chk("glitch_db_estado", int'(db_estado), 0);

        // Stop bit = 0 mid-frame returns parser to ESPERA_C
        send_char(7'h35, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        chk("stop_pre_db_estado", int'(db_estado), 1);
        s0 = n_eser;
        send_char(7'h36, 1'b0, 1'b1);
        repeat (2 * CB) @(negedge clock);
        chk("stop_erro_serial", n_eser - s0, 1);
        chk("stop_db_estado", int'(db_estado), 0);
        chk("stop_medida_held", int'(medida), 12'h999);

        // Reset after 7,8 and in the middle of the next character
        send_char(7'h37, 1'b0, 1'b0);
        send_char(7'h38, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        chk("rst2_pre_db_estado", int'(db_estado), 2);
        entrada_serial = 1'b0;
        repeat (300) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst2_medida", int'(medida), 0);
        chk("rst2_db_estado", int'(db_estado), 0);
        chk("rst2_pronto", int'(pronto), 0);
        reset = 1'b1;
        repeat (2 * CB) @(negedge clock);
        p0 = n_pronto;
        send_frame(7'h33, 7'h32, 7'h31);
        repeat (10) @(negedge clock);
        chk("f321_pronto_count", n_pronto - p0, 1);
        chk("f321_medida", int'(medida), 12'h321);

        chk("scoreboard_drained", esperado.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
